// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state encoding and port ids.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    function automatic logic other_port(input logic port_id);
        return ~port_id;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational 2-way round-robin picker with a bounded burst for the current owner.
module arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic [1:0]       req_i,
    input  logic             last_owner_i,
    input  logic [CNT_W-1:0] burst_cnt_i,
    output logic             grant_valid_o,
    output logic             grant_id_o
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic keep_owner;

    // burst_cnt_i == 0 only after reset: no burst is running, so the port opposite
    // last_owner (port 0) takes the first contested grant.
    assign keep_owner = (burst_cnt_i != '0) && (burst_cnt_i < BURST_MAX);

    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = PORT_CPU;
        case (req_i)
            2'b01:   grant_id_o = PORT_CPU;
            2'b10:   grant_id_o = PORT_DBG;
            2'b11:   grant_id_o = keep_owner ? last_owner_i : other_port(last_owner_i);
            default: grant_id_o = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port word data memory between the CPU port (0) and the loader/debug port (1).
// Optional misaligned-access blocking is enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wd0,
    output logic              ack0,
    output logic [DATA_W-1:0] rd0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd1,
    output logic              ack1,
    output logic [DATA_W-1:0] rd1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              dbg_state
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic              grant_valid;
    logic              grant_id;
    logic              misaligned_block;
    logic              access_ok;

    arb_rr_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .req_i         ({req1, req0}),
        .last_owner_i  (last_owner_q),
        .burst_cnt_i   (burst_cnt_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign misaligned_block = (addr_q[1:0] != 2'b00);
`else
    assign misaligned_block = 1'b0;
`endif

    // Reset landing in ACCESS cancels the access outright: no write, no ack.
    assign access_ok = (state_q == ST_ACCESS) && !reset;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
            last_owner_q <= PORT_DBG;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;

        mem_a  = addr_q;
        mem_wd = wd_q;
        mem_we = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        rd0    = '0;
        rd1    = '0;
        err0   = 1'b0;
        err1   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d      = ST_ACCESS;
                    owner_d      = grant_id;
                    we_d         = (grant_id == PORT_DBG) ? we1   : we0;
                    addr_d       = (grant_id == PORT_DBG) ? addr1 : addr0;
                    wd_d         = (grant_id == PORT_DBG) ? wd1   : wd0;
                    last_owner_d = grant_id;
                    if (grant_id != last_owner_q) begin
                        burst_cnt_d = CNT_W'(1);
                    end else if (burst_cnt_q < BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                mem_we  = access_ok && we_q && !misaligned_block;
                if (access_ok) begin
                    if (owner_q == PORT_DBG) begin
                        ack1 = 1'b1;
                        err1 = misaligned_block;
                        rd1  = misaligned_block ? '0 : mem_rd;
                    end else begin
                        ack0 = 1'b1;
                        err0 = misaligned_block;
                        rd0  = misaligned_block ? '0 : mem_rd;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural word memory and a response scoreboard.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wd0, addr1, wd1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rd0, rd1;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic        dbg_state;

    logic [31:0] mem [64];
    logic [32:0] exp_q[$];   // {port, read data}

    int tests_run    = 0;
    int tests_failed = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0),
        .ack0(ack0), .rd0(rd0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1),
        .ack1(ack1), .rd1(rd1), .err1(err1),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .dbg_state(dbg_state)
    );

    // clock / reset / memory model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic apply_reset();
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input logic port, input int max_cyc, output int cyc,
                            output logic [31:0] rd, output logic err);
        bit got = 0;
        cyc = 0;
        rd  = '0;
        err = 1'b0;
        while (!got && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if ((port == 1'b1) ? ack1 : ack0) begin
                got = 1;
                rd  = port ? rd1 : rd0;
                err = port ? err1 : err0;
            end
        end
        if (!got) cyc = -1;
    endtask

    // scenarios
    task automatic test_reset();
        apply_reset();
        tests_run++; if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL reset_state: got %0b want 0", dbg_state); end
        tests_run++; if ({ack0, ack1, err0, err1, mem_we} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 00000", {ack0, ack1, err0, err1, mem_we}); end
        tests_run++; if ({rd0, rd1} !== 64'h0) begin tests_failed++; $display("FAIL reset_rd: got %h want 0", {rd0, rd1}); end
        tests_run++; if ({mem_a, mem_wd} !== 64'h0) begin tests_failed++; $display("FAIL reset_mem_bus: got %h want 0", {mem_a, mem_wd}); end
    endtask

    task automatic test_write_read();
        int cyc;
        logic [31:0] rd;
        logic err;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wd0 = 32'hDEAD_BEEF;
        wait_ack(1'b0, 10, cyc, rd, err);
        tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL wr_latency: got %0d want 1", cyc); end
        tests_run++; if ({mem_we, mem_a, mem_wd} !== {1'b1, 32'h8, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL wr_bus: got %h want %h", {mem_we, mem_a, mem_wd}, {1'b1, 32'h8, 32'hDEAD_BEEF}); end
        tests_run++; if ({ack1, rd1} !== 33'h0) begin tests_failed++; $display("FAIL wr_port1_quiet: got %h want 0", {ack1, rd1}); end
        we0 = 1'b0; wd0 = '0;
        wait_ack(1'b0, 10, cyc, rd, err);
        tests_run++; if (cyc !== 2) begin tests_failed++; $display("FAIL rd_latency: got %0d want 2", cyc); end
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        tests_run++; if ({ack1, rd1, mem_we} !== 34'h0) begin tests_failed++; $display("FAIL rd_port1_quiet: got %h want 0", {ack1, rd1, mem_we}); end
        req0 = 1'b0;
        @(negedge clk);
        tests_run++; if (mem[2] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_commit: got %h want deadbeef", mem[2]); end
    endtask

    task automatic test_round_robin();
        int cyc = 0;
        int k = 0;
        logic [32:0] e;
        apply_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
        // Both ports held high from reset: blocks of MAX_BURST grants, port 0 first.
        for (int i = 0; i < 12; i++)
            exp_q.push_back(((i / 4) % 2 == 1) ? {1'b1, 32'h1000_0010} : {1'b0, 32'h1000_0008});
        while (k < 12 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack0 && ack1) begin
                tests_run++; tests_failed++; $display("FAIL rr_dual_ack: cycle %0d both acks high", cyc);
            end else if (ack0 || ack1) begin
                e = exp_q.pop_front();
                tests_run++; if ({ack1, ack1 ? rd1 : rd0} !== e) begin tests_failed++; $display("FAIL rr_grant%0d: got %h want %h", k, {ack1, ack1 ? rd1 : rd0}, e); end
                tests_run++; if (cyc !== 2 * k + 1) begin tests_failed++; $display("FAIL rr_timing%0d: got cycle %0d want %0d", k, cyc, 2 * k + 1); end
                k++;
                if (k == 12) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        tests_run++; if (k !== 12) begin tests_failed++; $display("FAIL rr_timeout: got %0d acks want 12", k); exp_q.delete(); req0 = 1'b0; req1 = 1'b0; end
        @(negedge clk);
    endtask

    task automatic test_burst_limit();
        int cyc;
        logic [31:0] rd;
        logic err;
        logic [3:0] order;
        apply_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        wait_ack(1'b0, 10, cyc, rd, err);
        tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL burst_first: got %0d want 1", cyc); end
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
        // Port 0 owns with burst_cnt=1: three more port 0 grants, then port 1.
        order = '0;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            while (!(ack0 || ack1) || cyc == 0) begin
                @(negedge clk);
                cyc++;
                if (cyc > 10) break;
            end
            order[i] = ack1;
            if (i == 3) req0 = 1'b0;
        end
        tests_run++; if (order !== 4'b1000) begin tests_failed++; $display("FAIL burst_order: got %b want 1000 (bit i = port of grant i)", order); end
        for (int i = 0; i < 6; i++) begin
            wait_ack(1'b1, 10, cyc, rd, err);
            tests_run++; if (cyc !== 2 || rd !== 32'h1000_0010) begin tests_failed++; $display("FAIL solo_port1_%0d: got cyc %0d rd %h want cyc 2 rd 10000010", i, cyc, rd); end
        end
        req0 = 1'b1;
        // Port 1 saturated its burst; the next contested grant goes to port 0.
        wait_ack(1'b0, 10, cyc, rd, err);
        tests_run++; if (cyc !== 2) begin tests_failed++; $display("FAIL burst_handover: got cyc %0d want 2", cyc); end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_during_access();
        int cyc;
        logic [31:0] rd;
        logic err;
        apply_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; wd1 = 32'h1234;
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++; if ({mem_we, ack1, ack0} !== 3'b000) begin tests_failed++; $display("FAIL rst_access_outputs: got %b want 000", {mem_we, ack1, ack0}); end
        @(negedge clk);
        reset = 1'b0; req1 = 1'b0; we1 = 1'b0;
        tests_run++; if ({dbg_state, ack1} !== 2'b00) begin tests_failed++; $display("FAIL rst_access_idle: got %b want 00", {dbg_state, ack1}); end
        tests_run++; if (mem[4] !== 32'h1000_0004) begin tests_failed++; $display("FAIL rst_access_mem: got %h want 10000004", mem[4]); end
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        req1 = 1'b1; addr1 = 32'h40;
        wait_ack(1'b0, 4, cyc, rd, err);
        tests_run++; if (cyc !== 1 || ack1 !== 1'b0) begin tests_failed++; $display("FAIL rst_access_regrant: got cyc %0d ack1 %b want cyc 1 ack1 0", cyc, ack1); end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_align();
        int cyc;
        logic [31:0] rd;
        logic err;
        apply_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h6; wd0 = 32'hCAFE_F00D;
        wait_ack(1'b0, 10, cyc, rd, err);
        req0 = 1'b0; we0 = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        tests_run++; if ({cyc == 1, err, mem_we} !== 3'b110) begin tests_failed++; $display("FAIL align_flags: got {ack_ok,err,we}=%b want 110", {cyc == 1, err, mem_we}); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL align_rd: got %h want 0", rd); end
        @(negedge clk);
        tests_run++; if (mem[1] !== 32'h1000_0001) begin tests_failed++; $display("FAIL align_mem: got %h want 10000001", mem[1]); end
`else
        tests_run++; if ({cyc == 1, err, mem_we} !== 3'b101) begin tests_failed++; $display("FAIL align_flags: got {ack_ok,err,we}=%b want 101", {cyc == 1, err, mem_we}); end
        tests_run++; if (mem_a !== 32'h6) begin tests_failed++; $display("FAIL align_addr: got %h want 6", mem_a); end
        @(negedge clk);
        tests_run++; if (mem[1] !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL align_mem: got %h want cafef00d", mem[1]); end
`endif
    endtask

    task automatic test_idle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++; if ({mem_we, ack0, ack1, dbg_state} !== 4'b0) begin tests_failed++; $display("FAIL idle_%0d: got %b want 0000", i, {mem_we, ack0, ack1, dbg_state}); end
            tests_run++; if ({rd0, rd1} !== 64'h0) begin tests_failed++; $display("FAIL idle_rd_%0d: got %h want 0", i, {rd0, rd1}); end
        end
    endtask

    // sequence and final report
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst_limit();
        test_reset_during_access();
        test_align();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
